// File: rtl/mmm_modexp_ctrl_if.sv
`timescale 1ns/1ps
// Handshake bundle between the exponentiation controller and an external
// Montgomery multiplier; the controller drives the master modport.
interface mmm_modexp_ctrl_if #(
    parameter int K_BITS = 8
) ();
    logic              mm_start;
    logic [K_BITS-1:0] mm_a;
    logic [K_BITS-1:0] mm_b;
    logic [K_BITS-1:0] mm_m;
    logic [K_BITS-1:0] mm_p;
    logic              mm_done;

    modport master (
        output mm_start, mm_a, mm_b, mm_m,
        input  mm_p, mm_done
    );

    modport slave (
        input  mm_start, mm_a, mm_b, mm_m,
        output mm_p, mm_done
    );
endinterface

// File: rtl/mmm_modexp_ctrl.sv
`timescale 1ns/1ps
// Left-to-right modular exponentiation sequencer driving an external Montgomery
// multiplier. Define MODEXP_LZ_SKIP_EN to skip leading exponent zero bits.
module mmm_modexp_ctrl #(
    parameter int K_BITS = 8,
    parameter int E_BITS = 8
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Start,
    input  logic [K_BITS-1:0] i_X,
    input  logic [E_BITS-1:0] i_E,
    input  logic [K_BITS-1:0] i_m,
    input  logic [K_BITS-1:0] i_R2,
    output logic [K_BITS-1:0] o_Y,
    output logic              o_Done,
    output logic              o_Busy,
    output logic [7:0]        o_Op_Count,
    output logic              o_mm_Start,
    output logic [K_BITS-1:0] o_mm_A,
    output logic [K_BITS-1:0] o_mm_B,
    output logic [K_BITS-1:0] o_mm_m,
    input  logic [K_BITS-1:0] i_mm_P,
    input  logic              i_mm_Done
);
    localparam int IW = (E_BITS > 1) ? $clog2(E_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_TO_MONT_X, S_TO_MONT_ONE, S_SQUARE, S_MULT, S_FROM_MONT, S_DONE
    } state_e;
    typedef enum logic [1:0] {PH_ENTRY, PH_ISSUE, PH_RELEASE} phase_e;

    state_e            state_q, state_d, op_next;
    phase_e            phase_q, phase_d;
    logic [IW-1:0]     idx_q, idx_d, idx_next;
    logic [K_BITS-1:0] x_q, x_d, m_q, m_d, r2_q, r2_d;
    logic [K_BITS-1:0] xbar_q, xbar_d, acc_q, acc_d, y_q, y_d;
    logic [K_BITS-1:0] mm_a_q, mm_a_d, mm_b_q, mm_b_d, mm_m_q, mm_m_d;
    logic [E_BITS-1:0] e_q, e_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d, mm_start_q, mm_start_d;
    logic              op_state, accept, launch, capture, advance;

    assign op_state = state_q inside {S_TO_MONT_X, S_TO_MONT_ONE, S_SQUARE, S_MULT, S_FROM_MONT};
    assign accept   = (state_q == S_IDLE) && i_Start && !i_mm_Done;
    assign launch   = op_state && (phase_q == PH_ENTRY) && !i_mm_Done;
    assign capture  = op_state && (phase_q == PH_ISSUE) && i_mm_Done;
    assign advance  = op_state && (phase_q == PH_RELEASE) && !i_mm_Done;

`ifdef MODEXP_LZ_SKIP_EN
    logic [IW-1:0] msb;
    always_comb begin
        msb = '0;
        for (int unsigned i = 0; i < E_BITS; i++) begin
            if (e_q[i]) msb = IW'(i);
        end
    end
`endif

    // Successor operation and bit index once the current operation is released.
    always_comb begin
        op_next  = state_q;
        idx_next = idx_q;
        case (state_q)
            S_TO_MONT_X: op_next = S_TO_MONT_ONE;
            S_TO_MONT_ONE: begin
`ifdef MODEXP_LZ_SKIP_EN
                if (e_q == '0 || msb == '0) begin
                    op_next = S_FROM_MONT;
                end else begin
                    op_next  = S_SQUARE;
                    idx_next = msb - IW'(1);
                end
`else
                op_next  = S_SQUARE;
                idx_next = IW'(E_BITS - 1);
`endif
            end
            S_SQUARE, S_MULT: begin
                if (state_q == S_SQUARE && e_q[idx_q]) begin
                    op_next = S_MULT;
                end else if (idx_q == '0) begin
                    op_next = S_FROM_MONT;
                end else begin
                    op_next  = S_SQUARE;
                    idx_next = idx_q - IW'(1);
                end
            end
            S_FROM_MONT: op_next = S_DONE;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_TO_MONT_X;
                    phase_d = PH_ENTRY;
                end
            end
            S_DONE: begin
                if (!i_Start) state_d = S_IDLE;
            end
            default: begin
                if (launch) phase_d = PH_ISSUE;
                if (capture) phase_d = PH_RELEASE;
                if (advance) begin
                    phase_d = PH_ENTRY;
                    state_d = op_next;
                    idx_d   = idx_next;
                end
            end
        endcase
    end

    always_comb begin
        x_d        = x_q;
        e_d        = e_q;
        m_d        = m_q;
        r2_d       = r2_q;
        xbar_d     = xbar_q;
        acc_d      = acc_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = done_q;
        mm_start_d = mm_start_q;
        mm_a_d     = mm_a_q;
        mm_b_d     = mm_b_q;
        mm_m_d     = mm_m_q;
        if (accept) begin
            x_d    = i_X;
            e_d    = i_E;
            m_d    = i_m;
            r2_d   = i_R2;
            cnt_d  = '0;
            busy_d = 1'b1;
        end
        if (launch) begin
            mm_start_d = 1'b1;
            mm_m_d     = m_q;
            case (state_q)
                S_TO_MONT_X:   begin mm_a_d = x_q;          mm_b_d = r2_q;         end
                S_TO_MONT_ONE: begin mm_a_d = K_BITS'(1);   mm_b_d = r2_q;         end
                S_SQUARE:      begin mm_a_d = acc_q;        mm_b_d = acc_q;        end
                S_MULT:        begin mm_a_d = acc_q;        mm_b_d = xbar_q;       end
                default:       begin mm_a_d = acc_q;        mm_b_d = K_BITS'(1);   end
            endcase
        end
        if (capture) begin
            mm_start_d = 1'b0;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            case (state_q)
                S_TO_MONT_X: xbar_d = i_mm_P;
                S_FROM_MONT: y_d    = i_mm_P;
                default:     acc_d  = i_mm_P;
            endcase
        end
        if (advance) begin
`ifdef MODEXP_LZ_SKIP_EN
            // The leading 1 of E turns acc straight into xbar without a multiply.
            if (state_q == S_TO_MONT_ONE && e_q != '0) acc_d = xbar_q;
`endif
            if (state_q == S_FROM_MONT) begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
        end
        if (state_q == S_DONE && !i_Start) done_d = 1'b0;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_ENTRY;
            idx_q      <= '0;
            x_q        <= '0;
            e_q        <= '0;
            m_q        <= '0;
            r2_q       <= '0;
            xbar_q     <= '0;
            acc_q      <= '0;
            y_q        <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mm_start_q <= 1'b0;
            mm_a_q     <= '0;
            mm_b_q     <= '0;
            mm_m_q     <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            e_q        <= e_d;
            m_q        <= m_d;
            r2_q       <= r2_d;
            xbar_q     <= xbar_d;
            acc_q      <= acc_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mm_start_q <= mm_start_d;
            mm_a_q     <= mm_a_d;
            mm_b_q     <= mm_b_d;
            mm_m_q     <= mm_m_d;
        end
    end

    assign o_Y        = y_q;
    assign o_Done     = done_q;
    assign o_Busy     = busy_q;
    assign o_Op_Count = cnt_q;
    assign o_mm_Start = mm_start_q;
    assign o_mm_A     = mm_a_q;
    assign o_mm_B     = mm_b_q;
    assign o_mm_m     = mm_m_q;
endmodule

// File: tb/tb_mmm_modexp_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for mmm_modexp_ctrl with a randomly delayed Montgomery
// multiplier model on the interface's slave side.
module tb_mmm_modexp_ctrl;
    localparam int K  = 8;
    localparam int EB = 8;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic [K-1:0]  x     = '0;
    logic [EB-1:0] e     = '0;
    logic [K-1:0]  m     = '0;
    logic [K-1:0]  r2    = '0;
    logic [K-1:0]  y;
    logic          done;
    logic          busy;
    logic [7:0]    op_cnt;

    mmm_modexp_ctrl_if #(.K_BITS(K)) mm ();

    mmm_modexp_ctrl #(.K_BITS(K), .E_BITS(EB)) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Start    (start),
        .i_X        (x),
        .i_E        (e),
        .i_m        (m),
        .i_R2       (r2),
        .o_Y        (y),
        .o_Done     (done),
        .o_Busy     (busy),
        .o_Op_Count (op_cnt),
        .o_mm_Start (mm.mm_start),
        .o_mm_A     (mm.mm_a),
        .o_mm_B     (mm.mm_b),
        .o_mm_m     (mm.mm_m),
        .i_mm_P     (mm.mm_p),
        .i_mm_Done  (mm.mm_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x, e, m, r2, y;
        int         cnt_full, cnt_lz;
    } vec_t;
    typedef struct {
        int y;
        int cnt;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    exp_t ex;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    // Reference Montgomery product A*B*2^-K mod M, bit-serial REDC.
    function automatic logic [K-1:0] mont(input logic [K-1:0] a, input logic [K-1:0] b,
                                          input logic [K-1:0] md);
        logic [K+1:0] t;
        t = '0;
        for (int i = 0; i < K; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, md};
            t = t >> 1;
        end
        if (t >= {2'b00, md}) t = t - {2'b00, md};
        return t[K-1:0];
    endfunction

    initial begin
        mm.mm_done = 1'b0;
        mm.mm_p    = '0;
        forever begin
            @(posedge clk); #1;
            if (mm.mm_start && !mm.mm_done) begin
                repeat ($urandom_range(1, 20)) @(posedge clk);
                #1;
                mm.mm_p    = mont(mm.mm_a, mm.mm_b, mm.mm_m);
                mm.mm_done = 1'b1;
                while (mm.mm_start) begin @(posedge clk); #1; end
                repeat ($urandom_range(0, 6)) @(posedge clk);
                #1;
                mm.mm_done = 1'b0;
            end
        end
    end

    logic          done_prev = 1'b0;
    logic          st_prev   = 1'b0;
    logic          mmd_prev  = 1'b0;
    logic [3*K-1:0] ops_prev = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (done && !done_prev) begin
                check("sb_has_entry", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    ex = sb.pop_front();
                    check("result_y", y, ex.y);
                    check("op_count", op_cnt, ex.cnt);
                    check("busy_low_at_done", busy, 0);
                end
            end
            if (mm.mm_start && !st_prev) check("start_while_mm_done", mmd_prev, 0);
            if (mm.mm_start && st_prev)
                check("operands_stable", {mm.mm_a, mm.mm_b, mm.mm_m}, ops_prev);
        end
        done_prev = done;
        st_prev   = mm.mm_start;
        mmd_prev  = mm.mm_done;
        ops_prev  = {mm.mm_a, mm.mm_b, mm.mm_m};
    end

    task automatic check_zero(input string tag);
        check({tag, "_y"}, y, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_opcnt"}, op_cnt, 0);
        check({tag, "_mm_start"}, mm.mm_start, 0);
        check({tag, "_mm_a"}, mm.mm_a, 0);
        check({tag, "_mm_b"}, mm.mm_b, 0);
        check({tag, "_mm_m"}, mm.mm_m, 0);
    endtask

    task automatic run_vec(input int v);
        int         budget;
        logic [K-1:0] y_held;
        exp_t       item;
        x  = vecs[v].x;
        e  = vecs[v].e;
        m  = vecs[v].m;
        r2 = vecs[v].r2;
        item.y = int'(vecs[v].y);
`ifdef MODEXP_LZ_SKIP_EN
        item.cnt = vecs[v].cnt_lz;
`else
        item.cnt = vecs[v].cnt_full;
`endif
        sb.push_back(item);
        start  = 1'b1;
        budget = 0;
        while (!busy && budget < 50) begin @(posedge clk); #1; budget++; end
        check("busy_rise", busy, 1);
        // Inputs are latched at acceptance; later changes must have no effect.
        x  = ~x;
        e  = ~e;
        m  = 8'd77;
        r2 = 8'd5;
        budget = 0;
        while (!done && budget < 3000) begin @(posedge clk); #1; budget++; end
        check("done_rise", done, 1);
        y_held = y;
        repeat (4) begin
            @(posedge clk); #1;
            check("hold_y", y, y_held);
            check("no_restart_busy", busy, 0);
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("done_drop", done, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int budget;
        vecs[0] = '{8'd2,   8'd10, 8'd225, 8'd61, 8'd124, 13, 7};
        vecs[1] = '{8'd3,   8'd5,  8'd101, 8'd88, 8'd41,  13, 6};
        vecs[2] = '{8'd211, 8'd0,  8'd225, 8'd61, 8'd1,   11, 3};
        vecs[3] = '{8'd15,  8'd2,  8'd225, 8'd61, 8'd0,   12, 4};
        vecs[4] = '{8'd211, 8'd1,  8'd225, 8'd61, 8'd211, 12, 3};
        vecs[5] = '{8'd0,   8'd7,  8'd225, 8'd61, 8'd0,   14, 7};
        vecs[6] = '{8'd2,   8'd8,  8'd101, 8'd88, 8'd54,  12, 6};

        repeat (3) @(posedge clk); #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) run_vec(v);

        // Abort a run in its first SQUARE with an asynchronous reset pulse.
        x = 8'd2; e = 8'd10; m = 8'd225; r2 = 8'd61;
        start  = 1'b1;
        budget = 0;
        while (!(op_cnt == 8'd2 && mm.mm_start) && budget < 3000) begin
            @(posedge clk); #1; budget++;
        end
        check("reached_square", int'(op_cnt == 8'd2 && mm.mm_start), 1);
        #2 rst = 1'b1;
        #1 check_zero("midrun_reset");
        start = 1'b0;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_vec(0);

        repeat (5) @(posedge clk); #1;
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog_timeout actual=running required=finished checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mmm_modexp_ctrl.md
MMM_MODEXP_CTRL -- requirements
Module: mmm_modexp_ctrl

Interface
REQ-001 The block SHALL have parameter K_BITS, default 8: modulus and operand width; Montgomery radix R = 2^K_BITS.
REQ-002 The block SHALL have parameter E_BITS, default 8: exponent width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset; ports i_Clk (clock) and i_Rst (reset).
REQ-004 The block SHALL have these ports, one per line (name, direction, width, meaning):
- i_Clk  in  1  clock
- i_Rst  in  1  asynchronous active-high reset
- i_Start  in  1  level request; held until o_Done
- i_X  in  K_BITS  base, X < m
- i_E  in  E_BITS  exponent
- i_m  in  K_BITS  modulus, odd, > 1
- i_R2  in  K_BITS  R^2 mod m, precomputed
- o_Y  out  K_BITS  result X^E mod m
- o_Done  out  1  result valid
- o_Busy  out  1  exponentiation in progress
- o_Op_Count  out  8  multiplier operations completed this run
- o_mm_Start  out  1  multiplier request (level)
- o_mm_A  out  K_BITS  multiplier operand A
- o_mm_B  out  K_BITS  multiplier operand B
- o_mm_m  out  K_BITS  multiplier modulus
- i_mm_P  in  K_BITS  multiplier result A*B*R^-1 mod m
- i_mm_Done  in  1  multiplier result valid

Function
REQ-005 In IDLE with i_Start high and i_mm_Done low, the block SHALL latch i_X, i_E, i_m and i_R2, clear o_Op_Count, set o_Busy and enter TO_MONT_X; input changes after that cycle SHALL be ignored.
REQ-006 The state sequence SHALL be IDLE -> TO_MONT_X (xbar = MMM(X,R2)) -> TO_MONT_ONE (acc = MMM(1,R2)) -> scan exponent MSB to LSB, per bit: SQUARE (acc = MMM(acc,acc)), then MULT (acc = MMM(acc,xbar)) only if the bit is 1 -> FROM_MONT (Y = MMM(acc,1)) -> DONE.
REQ-007 Each multiplier operation SHALL use two phases: ISSUE drives o_mm_Start high with o_mm_A, o_mm_B and o_mm_m stable until i_mm_Done is sampled high; i_mm_P is captured on that edge. RELEASE drives o_mm_Start low and waits until i_mm_Done is sampled low.
REQ-008 o_mm_Start SHALL be registered and rise exactly one cycle after the state is entered; a new operation SHALL never issue while i_mm_Done is high.
REQ-009 o_Op_Count SHALL increment on each captured i_mm_P and saturate at 255.
REQ-010 In DONE, the block SHALL drive o_Done high, hold o_Y stable and drive o_Busy low, until i_Start is sampled low; o_Done SHALL then drop and the block SHALL return to IDLE the next cycle.
REQ-011 If i_Start stays high after DONE, the block SHALL not restart until i_Start has been seen low.
REQ-012 E = 0 SHALL yield o_Y = 1.
REQ-013 X = 0 with E > 0 SHALL yield o_Y = 0.
REQ-014 Results SHALL be taken as returned by the multiplier; the block performs no arithmetic beyond operand muxing and bit scanning.
REQ-015 Latency SHALL equal the sum of the per-operation handshake times; it is not fixed.

Reset
REQ-016 i_Rst high SHALL immediately force IDLE and zero o_Y, o_Done, o_Busy, o_Op_Count, o_mm_Start, o_mm_A, o_mm_B and o_mm_m.
REQ-017 Reset mid-operation SHALL abort the run; after release, the next start SHALL wait for i_mm_Done low (REQ-005, REQ-008).

Configuration
REQ-018 Macro MODEXP_LZ_SKIP_EN SHALL control leading-zero skipping.
- Defined: exponent zero bits above the most significant 1 are skipped, and the leading 1 costs no operation (acc := xbar).
- Undefined: all E_BITS bits are processed.
- o_Y SHALL be identical in both builds.

Verification
REQ-019 X=2, E=10, m=225, R2=61 -> o_Y=124; o_Op_Count=13 without the macro, 7 with it.
REQ-020 X=3, E=5, m=101, R2=88 -> o_Y=41.
REQ-021 X=211, E=0, m=225, R2=61 -> o_Y=1; o_Op_Count=11 without the macro, 3 with it.
REQ-022 X=15, E=2, m=225, R2=61 -> o_Y=0; X=211, E=1 -> o_Y=211.
REQ-023 Multiplier model with random 1-20 cycle Done delay and random Done-drop delay -> o_mm_A, o_mm_B and o_mm_m stable while o_mm_Start is high, and o_mm_Start never rises while i_mm_Done is high.
REQ-024 i_Rst pulsed during SQUARE -> all outputs zero at once; a following run of X=2, E=10, m=225 returns 124.
